// File: rtl/hipass_tag_rx.sv
`timescale 1ns/1ps
// Hi-pass tag reader: decodes one start/4-data/parity/stop frame per car. Latency is ts low to done = BIT_CYC/2 + 6*BIT_CYC + 1 cycles.
// No backpressure: outputs are registered status levels and a done pulse. car low aborts a read, or clears a finished one.
module hipass_tag_rx #(
  parameter int BIT_CYC = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car,
  input  logic       tag_in,
  output logic [1:0] en,
  output logic [3:0] hipass,
  output logic       done
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = $clog2(BIT_CYC) + 1;
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] LAST_B  = CW'(5);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, START_CHK, RECV, DONE_OK, DONE_ERR
  } state_t;

  state_t        state;
  logic          sync1, ts;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] bcnt;
  logic [4:0]    sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      ts    <= 1'b1;
    end else begin
      sync1 <= tag_in;
      ts    <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      en     <= 2'd0;
      hipass <= 4'd0;
      done   <= 1'b0;
      tcnt   <= '0;
      cnt    <= '0;
      bcnt   <= '0;
      sh     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          en     <= 2'd0;
          hipass <= 4'd0;
          if (car) begin
            state <= WAIT_START;
            en    <= 2'd1;
            tcnt  <= '0;
          end
        end
        WAIT_START: begin
          if (!car) begin
            state <= IDLE;
            en    <= 2'd0;
          end else if (!ts) begin
            state <= START_CHK;
            cnt   <= '0;
            bcnt  <= '0;
          end else if (tcnt >= TO_M1) begin
            state  <= DONE_ERR;
            en     <= 2'd2;
            hipass <= 4'd0;
            done   <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        START_CHK: begin
          if (!car) begin
            state <= IDLE;
            en    <= 2'd0;
          end else begin
            // Timeout keeps running through glitch checks so a noisy line still times out.
            tcnt <= tcnt + 1'b1;
            if (cnt == HALF_M1) begin
              cnt   <= '0;
              state <= ts ? WAIT_START : RECV;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RECV: begin
          if (!car) begin
            state <= IDLE;
            en    <= 2'd0;
          end else if (cnt == FULL_M1) begin
            cnt <= '0;
            if (bcnt == LAST_B) begin
              done <= 1'b1;
              if (((^sh) == 1'b0) && ts) begin
                state  <= DONE_OK;
                en     <= 2'd3;
                hipass <= sh[3:0];
              end else begin
                state  <= DONE_ERR;
                en     <= 2'd2;
                hipass <= 4'd0;
              end
            end else begin
              // LSB first: after five shifts sh = {p, d3, d2, d1, d0}.
              sh   <= {ts, sh[4:1]};
              bcnt <= bcnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE_OK, DONE_ERR: begin
          if (!car) begin
            state  <= IDLE;
            en     <= 2'd0;
            hipass <= 4'd0;
          end
        end
        default: begin
          state  <= IDLE;
          en     <= 2'd0;
          hipass <= 4'd0;
        end
      endcase
    end
  end

endmodule
